pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Parametrised successor to the single-register main control decoder. Decodes the 7-bit RISC-V opcode in ID and carries the control bundle through three pipeline registers (ID/EX, EX/MEM, MEM/WB). Each stage receives only the signals it consumes. Adds stall/flush bubble insertion, valid tracking, an extended instruction set selectable by a mode parameter, and illegal-opcode detection with a saturating error counter.

Parameters:
OPCODE_W, 7, opcode field width; decode compares against the low 7 bits, and upper bits must be 0 or the opcode is illegal
ENABLE_EXT, 1, 1 = also decode I-ALU/jal/jalr/lui; 0 = only R/lw/sw/beq, all others illegal
ERR_CNT_W, 8, width of saturating illegal-opcode counter

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
id_valid  in  1  Opcode holds a real instruction this cycle
Opcode  in  OPCODE_W  instruction opcode from IF/ID
stall  in  1  load-use stall: insert bubble into ID/EX
flush  in  1  taken branch/jump: bubble into ID/EX and EX/MEM
ex_valid  out  1  EX stage holds a real instruction
ex_ALUSrc  out  1  ALU B = immediate
ex_RegDst  out  1  write register from rd (R-type)
ex_ALUOp  out  2  00 add, 01 branch compare, 10 R funct, 11 I funct
ex_Branch  out  1  conditional branch
ex_Jump  out  1  jal/jalr
ex_JumpReg  out  1  jalr (target from rs1)
mem_valid  out  1  MEM stage holds a real instruction
mem_MemRead  out  1  data memory read
mem_MemWrite  out  1  data memory write
wb_RegWrite  out  1  register file write
wb_MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4
illegal  out  1  one-cycle pulse, registered
err_count  out  ERR_CNT_W  illegal opcodes seen, saturating

Behaviour:
- Reset: all outputs, pipeline registers and err_count go to 0 immediately, independent of CLK. Reset mid-pipeline discards all in-flight bundles.
- Decode table (combinational, internal), fields ALUSrc, RegDst, ALUOp, Branch, Jump, JumpReg, MemRead, MemWrite, RegWrite, MemtoReg:
  - 51 R: 0,1,10,0,0,0,0,0,1,00
  - 3 lw: 1,0,00,0,0,0,1,0,1,01
  - 35 sw: 1,0,00,0,0,0,0,1,0,00
  - 99 beq: 0,0,01,1,0,0,0,0,0,00
  - EXT 19 I-ALU: 1,0,11,0,0,0,0,0,1,00
  - EXT 111 jal: 0,0,00,0,1,0,0,0,1,10
  - EXT 103 jalr: 1,0,00,0,1,1,0,0,1,10
  - EXT 55 lui: 1,0,00,0,0,0,0,0,1,00
- Bubble = valid 0 with all control bits 0. Unknown opcodes never retain previous values.
- Edge t with id_valid=1, legal opcode, no stall/flush: the bundle appears on ex_* after edge t, mem_* after t+1, wb_* after t+2. Fixed latency 1/2/3 cycles.
- id_valid=0 produces a bubble into ID/EX. It is not counted as illegal.
- stall=1: ID/EX loads a bubble. EX/MEM and MEM/WB advance normally. The upstream stage holds Opcode stable and re-presents it.
- flush=1: ID/EX and EX/MEM load bubbles. MEM/WB advances from the old EX/MEM.
- stall and flush together: identical to flush.
- Illegal (id_valid=1, not in the table for the current ENABLE_EXT, or upper bits nonzero):
  - a bubble enters ID/EX;
  - illegal=1 for the following cycle;
  - err_count increments and holds at all-ones.
- An illegal opcode with stall or flush asserted is suppressed: no pulse, no count.
- wb_RegWrite is only ever 1 when the corresponding wb bundle was valid. Bubbles never write.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IALU, OP_JAL, OP_JALR, OP_LUI;
  - ALUOp encodings and MemtoReg select encodings;
  - packed struct types ex_ctrl_t, mem_ctrl_t, wb_ctrl_t, with a bubble constant for each.
- Sub-module ctrl_decode: purely combinational opcode-to-bundle decode plus the legal flag, parametrised by ENABLE_EXT. The pipeline registers and counter live in the top module.

Test Plan:
- Reset, then lw (3) at edge 1 → ex_ALUSrc=1, ex_ALUOp=00 after edge 1; mem_MemRead=1 after edge 2; wb_RegWrite=1, wb_MemtoReg=01 after edge 3.
- Back-to-back R(51), sw(35), beq(99), jal(111) → each stage shows the correct table row in order with no gaps; jal gives wb_MemtoReg=10.
- lw then stall for one cycle while re-presenting R → ex_valid=0 for one cycle; lw continues to MEM/WB undisturbed; R appears in EX one cycle late.
- flush with sw in EX and R in ID → mem_MemWrite never asserts for that sw; ex_valid=0 and mem_valid=0 next cycle.
- ENABLE_EXT=0, Opcode=19 → illegal pulse for 1 cycle, err_count 0→1, ex_valid=0. Repeat 300 times with ERR_CNT_W=8 → err_count saturates at 255.
- Assert Reset asynchronously mid-stream between edges → all outputs 0 immediately; the first instruction after deassertion has normal 1/2/3 latency.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-path types and encodings for the pipelined main decoder.
package ctrl_pkg;

   localparam int unsigned OP_BASE_W = 7;
   localparam int unsigned ALUOP_W   = 2;
   localparam int unsigned WBSEL_W   = 2;

   // RISC-V base opcodes (low 7 bits of the instruction)
   localparam logic [OP_BASE_W-1:0] OP_R      = 7'd51;
   localparam logic [OP_BASE_W-1:0] OP_LOAD   = 7'd3;
   localparam logic [OP_BASE_W-1:0] OP_STORE  = 7'd35;
   localparam logic [OP_BASE_W-1:0] OP_BRANCH = 7'd99;
   localparam logic [OP_BASE_W-1:0] OP_IALU   = 7'd19;
   localparam logic [OP_BASE_W-1:0] OP_JAL    = 7'd111;
   localparam logic [OP_BASE_W-1:0] OP_JALR   = 7'd103;
   localparam logic [OP_BASE_W-1:0] OP_LUI    = 7'd55;

   // ALU operation class handed to the ALU control
   localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RFUNCT = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_IFUNCT = 2'b11;

   // Write-back data source
   localparam logic [WBSEL_W-1:0] WBSEL_ALU = 2'b00;
   localparam logic [WBSEL_W-1:0] WBSEL_MEM = 2'b01;
   localparam logic [WBSEL_W-1:0] WBSEL_PC4 = 2'b10;

   typedef struct packed {
      logic               valid;
      logic               alu_src;
      logic               reg_dst;
      logic [ALUOP_W-1:0] alu_op;
      logic               branch;
      logic               jump;
      logic               jump_reg;
   } ex_ctrl_t;

   typedef struct packed {
      logic valid;
      logic mem_read;
      logic mem_write;
   } mem_ctrl_t;

   typedef struct packed {
      logic               valid;
      logic               reg_write;
      logic [WBSEL_W-1:0] memto_reg;
   } wb_ctrl_t;

   // ID/EX carries everything still needed downstream; EX/MEM drops the EX fields
   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } idex_t;

   typedef struct packed {
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } exmem_t;

   localparam ex_ctrl_t  EX_BUBBLE    = '0;
   localparam mem_ctrl_t MEM_BUBBLE   = '0;
   localparam wb_ctrl_t  WB_BUBBLE    = '0;
   localparam idex_t     IDEX_BUBBLE  = '0;
   localparam exmem_t    EXMEM_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control decode with legality flag.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W   = 7,
   parameter bit          ENABLE_EXT = 1'b1
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output logic                legal_c,
   output ex_ctrl_t            ex_c,
   output mem_ctrl_t           mem_c,
   output wb_ctrl_t            wb_c
);

   logic [OP_BASE_W-1:0] op_base;
   logic                 hi_zero;
   logic                 known;

   assign op_base = opcode_i[OP_BASE_W-1:0];
   assign hi_zero = (opcode_i & ~OPCODE_W'({OP_BASE_W{1'b1}})) == '0;

   // Table lookup; anything unmatched decodes to a bubble
   always_comb begin
      ex_c  = EX_BUBBLE;
      mem_c = MEM_BUBBLE;
      wb_c  = WB_BUBBLE;
      known = 1'b0;
      case (op_base)
         OP_R: begin
            known          = 1'b1;
            ex_c.reg_dst   = 1'b1;
            ex_c.alu_op    = ALUOP_RFUNCT;
            wb_c.reg_write = 1'b1;
            wb_c.memto_reg = WBSEL_ALU;
         end
         OP_LOAD: begin
            known          = 1'b1;
            ex_c.alu_src   = 1'b1;
            ex_c.alu_op    = ALUOP_ADD;
            mem_c.mem_read = 1'b1;
            wb_c.reg_write = 1'b1;
            wb_c.memto_reg = WBSEL_MEM;
         end
         OP_STORE: begin
            known           = 1'b1;
            ex_c.alu_src    = 1'b1;
            ex_c.alu_op     = ALUOP_ADD;
            mem_c.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            known       = 1'b1;
            ex_c.alu_op = ALUOP_BRANCH;
            ex_c.branch = 1'b1;
         end
         OP_IALU: begin
            known          = ENABLE_EXT;
            ex_c.alu_src   = 1'b1;
            ex_c.alu_op    = ALUOP_IFUNCT;
            wb_c.reg_write = 1'b1;
         end
         OP_JAL: begin
            known          = ENABLE_EXT;
            ex_c.jump      = 1'b1;
            wb_c.reg_write = 1'b1;
            wb_c.memto_reg = WBSEL_PC4;
         end
         OP_JALR: begin
            known          = ENABLE_EXT;
            ex_c.alu_src   = 1'b1;
            ex_c.jump      = 1'b1;
            ex_c.jump_reg  = 1'b1;
            wb_c.reg_write = 1'b1;
            wb_c.memto_reg = WBSEL_PC4;
         end
         OP_LUI: begin
            known          = ENABLE_EXT;
            ex_c.alu_src   = 1'b1;
            wb_c.reg_write = 1'b1;
         end
         default: known = 1'b0;
      endcase

      legal_c = known & hi_zero;
      if (legal_c) begin
         ex_c.valid  = 1'b1;
         mem_c.valid = 1'b1;
         wb_c.valid  = 1'b1;
      end else begin
         ex_c  = EX_BUBBLE;
         mem_c = MEM_BUBBLE;
         wb_c  = WB_BUBBLE;
      end
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Main control decoder with ID/EX, EX/MEM, MEM/WB control pipeline,
// stall/flush bubbles and a saturating illegal-opcode counter.
module pipelined_control_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W   = 7,
   parameter bit          ENABLE_EXT = 1'b1,
   parameter int unsigned ERR_CNT_W  = 8
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 id_valid,
   input  logic [OPCODE_W-1:0]  Opcode,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 ex_valid,
   output logic                 ex_ALUSrc,
   output logic                 ex_RegDst,
   output logic [ALUOP_W-1:0]   ex_ALUOp,
   output logic                 ex_Branch,
   output logic                 ex_Jump,
   output logic                 ex_JumpReg,
   output logic                 mem_valid,
   output logic                 mem_MemRead,
   output logic                 mem_MemWrite,
   output logic                 wb_RegWrite,
   output logic [WBSEL_W-1:0]   wb_MemtoReg,
   output logic                 illegal,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic      dec_legal;
   ex_ctrl_t  dec_ex;
   mem_ctrl_t dec_mem;
   wb_ctrl_t  dec_wb;

   idex_t                idex_d,    idex_q;
   exmem_t               exmem_d,   exmem_q;
   wb_ctrl_t             memwb_d,   memwb_q;
   logic                 illegal_d, illegal_q;
   logic [ERR_CNT_W-1:0] err_d,     err_q;

   ctrl_decode #(
      .OPCODE_W   (OPCODE_W),
      .ENABLE_EXT (ENABLE_EXT)
   ) u_decode (
      .opcode_i (Opcode),
      .legal_c  (dec_legal),
      .ex_c     (dec_ex),
      .mem_c    (dec_mem),
      .wb_c     (dec_wb)
   );

   // Next-state for the control pipeline and the error tracking
   always_comb begin
      idex_d    = IDEX_BUBBLE;
      exmem_d   = EXMEM_BUBBLE;
      memwb_d   = exmem_q.wb;
      illegal_d = 1'b0;
      err_d     = err_q;

      if (id_valid && dec_legal && !stall && !flush) begin
         idex_d.ex  = dec_ex;
         idex_d.mem = dec_mem;
         idex_d.wb  = dec_wb;
      end

      if (!flush) begin
         exmem_d.mem = idex_q.mem;
         exmem_d.wb  = idex_q.wb;
      end

      // An illegal opcode that is being stalled or flushed is not reported
      illegal_d = id_valid && !dec_legal && !stall && !flush;
      if (illegal_d && (err_q != '1)) begin
         err_d = err_q + ERR_CNT_W'(1);
      end
   end

   // Pipeline and counter registers
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         idex_q    <= IDEX_BUBBLE;
         exmem_q   <= EXMEM_BUBBLE;
         memwb_q   <= WB_BUBBLE;
         illegal_q <= 1'b0;
         err_q     <= '0;
      end else begin
         idex_q    <= idex_d;
         exmem_q   <= exmem_d;
         memwb_q   <= memwb_d;
         illegal_q <= illegal_d;
         err_q     <= err_d;
      end
   end

   assign ex_valid     = idex_q.ex.valid;
   assign ex_ALUSrc    = idex_q.ex.alu_src;
   assign ex_RegDst    = idex_q.ex.reg_dst;
   assign ex_ALUOp     = idex_q.ex.alu_op;
   assign ex_Branch    = idex_q.ex.branch;
   assign ex_Jump      = idex_q.ex.jump;
   assign ex_JumpReg   = idex_q.ex.jump_reg;
   assign mem_valid    = exmem_q.mem.valid;
   assign mem_MemRead  = exmem_q.mem.mem_read;
   assign mem_MemWrite = exmem_q.mem.mem_write;
   // Bubbles can never write the register file
   assign wb_RegWrite  = memwb_q.valid & memwb_q.reg_write;
   assign wb_MemtoReg  = memwb_q.memto_reg;
   assign illegal      = illegal_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: two DUTs (extended set, 8-bit opcode / base set, 7-bit opcode)
// driven by the same stream and checked against an instruction-level model.
module tb_pipelined_control_unit;

   localparam int unsigned VW = 23;

   logic CLK = 1'b0;
   logic Reset;
   logic id_valid, stall, flush;
   logic [7:0] op8;

   logic [1:0]       ex_valid, ex_ALUSrc, ex_RegDst, ex_Branch, ex_Jump, ex_JumpReg;
   logic [1:0][1:0]  ex_ALUOp, wb_MemtoReg;
   logic [1:0]       mem_valid, mem_MemRead, mem_MemWrite, wb_RegWrite, illegal;
   logic [1:0][7:0]  err_count;

   int total = 0;
   int bad   = 0;

   logic [VW-1:0] exp_q0[$];
   logic [VW-1:0] exp_q1[$];

   // Instruction-level model: which opcode sits in each stage, per DUT
   bit         m_ex_v[2], m_mem_v[2], m_wb_v[2], m_ill[2];
   logic [7:0] m_ex_op[2], m_mem_op[2], m_wb_op[2];
   int         m_err[2];

   always #5 CLK = ~CLK;

   pipelined_control_unit #(.OPCODE_W(8), .ENABLE_EXT(1'b1), .ERR_CNT_W(8)) u_dut_ext (
      .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .Opcode(op8), .stall(stall), .flush(flush),
      .ex_valid(ex_valid[0]), .ex_ALUSrc(ex_ALUSrc[0]), .ex_RegDst(ex_RegDst[0]),
      .ex_ALUOp(ex_ALUOp[0]), .ex_Branch(ex_Branch[0]), .ex_Jump(ex_Jump[0]),
      .ex_JumpReg(ex_JumpReg[0]), .mem_valid(mem_valid[0]), .mem_MemRead(mem_MemRead[0]),
      .mem_MemWrite(mem_MemWrite[0]), .wb_RegWrite(wb_RegWrite[0]), .wb_MemtoReg(wb_MemtoReg[0]),
      .illegal(illegal[0]), .err_count(err_count[0])
   );

   pipelined_control_unit #(.OPCODE_W(7), .ENABLE_EXT(1'b0), .ERR_CNT_W(8)) u_dut_base (
      .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .Opcode(op8[6:0]), .stall(stall), .flush(flush),
      .ex_valid(ex_valid[1]), .ex_ALUSrc(ex_ALUSrc[1]), .ex_RegDst(ex_RegDst[1]),
      .ex_ALUOp(ex_ALUOp[1]), .ex_Branch(ex_Branch[1]), .ex_Jump(ex_Jump[1]),
      .ex_JumpReg(ex_JumpReg[1]), .mem_valid(mem_valid[1]), .mem_MemRead(mem_MemRead[1]),
      .mem_MemWrite(mem_MemWrite[1]), .wb_RegWrite(wb_RegWrite[1]), .wb_MemtoReg(wb_MemtoReg[1]),
      .illegal(illegal[1]), .err_count(err_count[1])
   );

   // {legal, ALUSrc, RegDst, ALUOp[1:0], Branch, Jump, JumpReg, MemRead, MemWrite, RegWrite, MemtoReg[1:0]}
   function automatic logic [12:0] ref_row(logic [7:0] op, bit ext);
      logic [12:0] r;
      r = '0;
      if (op[7] == 1'b0) begin
         case (op[6:0])
            7'd51:  r = {1'b1, 12'b0_1_10_0_0_0_0_0_1_00};
            7'd3:   r = {1'b1, 12'b1_0_00_0_0_0_1_0_1_01};
            7'd35:  r = {1'b1, 12'b1_0_00_0_0_0_0_1_0_00};
            7'd99:  r = {1'b1, 12'b0_0_01_1_0_0_0_0_0_00};
            7'd19:  if (ext) r = {1'b1, 12'b1_0_11_0_0_0_0_0_1_00};
            7'd111: if (ext) r = {1'b1, 12'b0_0_00_0_1_0_0_0_1_10};
            7'd103: if (ext) r = {1'b1, 12'b1_0_00_0_1_1_0_0_1_10};
            7'd55:  if (ext) r = {1'b1, 12'b1_0_00_0_0_0_0_0_1_00};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] exp_vec(int d);
      logic [12:0] re, rm, rw;
      re = m_ex_v[d]  ? ref_row(m_ex_op[d],  d == 0) : 13'd0;
      rm = m_mem_v[d] ? ref_row(m_mem_op[d], d == 0) : 13'd0;
      rw = m_wb_v[d]  ? ref_row(m_wb_op[d],  d == 0) : 13'd0;
      return {m_ex_v[d], re[11], re[10], re[9:8], re[7], re[6], re[5],
              m_mem_v[d], rm[4], rm[3],
              rw[2], rw[1:0],
              m_ill[d], 8'(m_err[d])};
   endfunction

   function automatic logic [VW-1:0] actual(int d);
      return {ex_valid[d], ex_ALUSrc[d], ex_RegDst[d], ex_ALUOp[d], ex_Branch[d], ex_Jump[d],
              ex_JumpReg[d], mem_valid[d], mem_MemRead[d], mem_MemWrite[d],
              wb_RegWrite[d], wb_MemtoReg[d], illegal[d], err_count[d]};
   endfunction

   task automatic check(string name, logic [VW-1:0] act, logic [VW-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         m_ex_v[d] = 0; m_mem_v[d] = 0; m_wb_v[d] = 0; m_ill[d] = 0; m_err[d] = 0;
         m_ex_op[d] = '0; m_mem_op[d] = '0; m_wb_op[d] = '0;
      end
   endtask

   // Present one ID-stage input for the next edge and record the expected result
   task automatic step(bit v, logic [7:0] op, bit st, bit fl);
      logic [7:0] eop;
      bit lg;
      @(negedge CLK);
      id_valid = v; op8 = op; stall = st; flush = fl;
      for (int d = 0; d < 2; d++) begin
         eop = (d == 0) ? op : {1'b0, op[6:0]};
         lg  = ref_row(eop, d == 0) == 13'd0 ? 1'b0 : ref_row(eop, d == 0)[12];
         m_wb_v[d]  = m_mem_v[d];
         m_wb_op[d] = m_mem_op[d];
         m_mem_v[d]  = fl ? 1'b0 : m_ex_v[d];
         m_mem_op[d] = m_ex_op[d];
         m_ex_v[d]  = v && lg && !st && !fl;
         m_ex_op[d] = eop;
         m_ill[d]   = v && !lg && !st && !fl;
         if (m_ill[d] && m_err[d] < 255) m_err[d]++;
         if (d == 0) exp_q0.push_back(exp_vec(0));
         else        exp_q1.push_back(exp_vec(1));
      end
   endtask

   task automatic async_reset();
      @(negedge CLK);
      #2 Reset = 1'b1;
      #1;
      check("reset_now_ext",  actual(0), '0);
      check("reset_now_base", actual(1), '0);
      model_clear();
      @(negedge CLK);
      Reset = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic rand_run(int n);
      logic [7:0] legal_ops[8];
      logic [7:0] op;
      legal_ops = '{8'd51, 8'd3, 8'd35, 8'd99, 8'd19, 8'd111, 8'd103, 8'd55};
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 9))
            8:       op = 8'($urandom);
            9:       op = legal_ops[$urandom_range(0, 7)] | 8'h80;
            default: op = legal_ops[$urandom_range(0, 7)];
         endcase
         step($urandom_range(0, 4) != 0, op, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end
   endtask

   // Monitor: every edge the DUTs present a new output set; pop and compare
   always @(posedge CLK) begin
      logic [VW-1:0] e;
      #1;
      if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); check("pipe_ext",  actual(0), e); end
      if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); check("pipe_base", actual(1), e); end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      Reset = 1'b1; id_valid = 1'b0; stall = 1'b0; flush = 1'b0; op8 = '0;
      model_clear();
      #2;
      check("reset_init_ext",  actual(0), '0);
      check("reset_init_base", actual(1), '0);
      @(negedge CLK);
      Reset = 1'b0;

      // Single load through all stages
      step(1, 8'd3, 0, 0);
      repeat (3) step(0, 8'd0, 0, 0);
      // Back-to-back R, sw, beq, jal
      step(1, 8'd51, 0, 0); step(1, 8'd35, 0, 0); step(1, 8'd99, 0, 0); step(1, 8'd111, 0, 0);
      repeat (3) step(0, 8'd0, 0, 0);
      // Load-use stall re-presenting R
      step(1, 8'd3, 0, 0); step(1, 8'd51, 1, 0); step(1, 8'd51, 0, 0);
      repeat (3) step(0, 8'd0, 0, 0);
      // Flush with sw in EX and R in ID
      step(1, 8'd35, 0, 0); step(1, 8'd51, 0, 1);
      repeat (3) step(0, 8'd0, 0, 0);
      // Suppressed illegal under stall, then under stall+flush, plus upper-bit illegal
      step(1, 8'd0, 1, 0); step(1, 8'd0, 1, 1); step(1, 8'h83, 0, 0);
      repeat (2) step(0, 8'd0, 0, 0);
      // I-ALU: legal on the extended DUT, illegal and counted on the base DUT until saturation
      repeat (300) step(1, 8'd19, 0, 0);
      repeat (2) step(0, 8'd0, 0, 0);
      @(posedge CLK); #2;
      check("err_saturated_base", {15'd0, err_count[1]}, {15'd0, 8'd255});

      rand_run(400);
      async_reset();
      step(1, 8'd3, 0, 0);
      repeat (3) step(0, 8'd0, 0, 0);
      rand_run(200);
      repeat (4) step(0, 8'd0, 0, 0);
      @(posedge CLK); #3;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
